// File: rtl/uart_boot_pkg.sv
// Shared constants and types for the UART boot loader: UART register map,
// status words returned to the host, and the loader state encoding.
package uart_boot_pkg;

    localparam logic [63:0] UART_RX_COUNT = 64'd0;
    localparam logic [63:0] UART_RX_POP   = 64'd8;
    localparam logic [63:0] UART_TX_COUNT = 64'd16;
    localparam logic [63:0] UART_TX_DATA  = 64'd24;

    // "BOOT_OK\n" and "BOOT_ER\n", first character in the least significant byte
    localparam logic [63:0] BOOT_ACK_WORD = 64'h0A4B4F5F544F4F42;
    localparam logic [63:0] BOOT_NAK_WORD = 64'h0A52455F544F4F42;

    typedef enum logic [3:0] {
        ST_IDLE_WAIT,
        ST_POLL_HDR,
        ST_POP_HDR,
        ST_CHECK,
        ST_POLL_DATA,
        ST_POP_DATA,
        ST_MEM_WR,
        ST_SEND_STATUS,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/axil_interface_if.sv
// AXI4-Lite bundle with 64-bit address and data, plus the read-master and
// write-master views used by the boot loader.
interface axil_interface_if;

    logic [63:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [63:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport rd_mst (output araddr, arvalid, rready, input arready, rdata, rresp, rvalid);
    modport wr_mst (output awaddr, awvalid, wdata, wstrb, wvalid, bready,
                    input awready, wready, bresp, bvalid);

endinterface

// File: rtl/axil_single_write.sv
// One-shot AXI4-Lite write master: a start pulse launches AW and W together,
// each drops on its own handshake, and done pulses on the B handshake.
module axil_single_write (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] addr,
    input  logic [63:0] data,
    output logic [63:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready,
    output logic        done
);

    logic busy;

    assign wstrb = 8'hFF;
    assign done  = bready && bvalid;

    // NOTE: reset is synchronous, so it lives inside the clocked block and drops every valid on the next edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            awaddr  <= '0;
            wdata   <= '0;
        end else if (start && !busy) begin
            busy    <= 1'b1;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awaddr  <= addr;
            wdata   <= data;
        end else begin
            if (awvalid && awready) awvalid <= 1'b0;
            if (wvalid && wready) wvalid <= 1'b0;
            // Accept the response only once neither address nor data is still pending.
            if (busy && !bready && !(awvalid && !awready) && !(wvalid && !wready))
                bready <= 1'b1;
            if (bready && bvalid) begin
                bready <= 1'b0;
                busy   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a length-prefixed image from the UART RX FIFO into memory, holds the
// core in reset until the last word is written, then reports ACK/NAK on UART TX.
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR       = 64'h0,
    parameter int          MAX_IMAGE_BYTES = 4096,
    parameter int          POLL_INTERVAL   = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    axil_interface_if.rd_mst                    uart_rd,
    axil_interface_if.wr_mst                    uart_wr,
    axil_interface_if.wr_mst                    mem_wr,
    output logic                                core_rst_n,
    output logic                                done,
    output logic                                error,
    output logic [$clog2(MAX_IMAGE_BYTES/8):0]  words_loaded
);

    localparam int WCW = $clog2(MAX_IMAGE_BYTES/8) + 1;
    localparam int PCW = $clog2(POLL_INTERVAL + 1);

    loader_state_t  state;
    logic           data_phase;
    logic           rd_valid;
    logic           rd_ready;
    logic [63:0]    rd_addr;
    logic [63:0]    image_len;
    logic [63:0]    word;
    logic [63:0]    addr;
    logic [WCW-1:0] words_remaining;
    logic [PCW-1:0] wait_cnt;
    logic           wr_issued;
    logic           ack;
    logic           rd_idle, rd_fire;
    logic           mem_start, mem_done, tx_start, tx_done;
    logic           unused;

    assign uart_rd.araddr  = rd_addr;
    assign uart_rd.arvalid = rd_valid;
    assign uart_rd.rready  = rd_ready;
    assign rd_idle   = !rd_valid && !rd_ready;
    assign rd_fire   = rd_ready && uart_rd.rvalid;
    assign mem_start = (state == ST_MEM_WR) && !wr_issued;
    assign tx_start  = (state == ST_SEND_STATUS) && !wr_issued;
    assign unused    = ^{uart_rd.rresp, uart_wr.bresp, mem_wr.bresp};

    axil_single_write u_mem_wr (
        .clk(clk), .rst_n(rst_n), .start(mem_start), .addr(addr), .data(word),
        .awaddr(mem_wr.awaddr), .awvalid(mem_wr.awvalid), .awready(mem_wr.awready),
        .wdata(mem_wr.wdata), .wstrb(mem_wr.wstrb), .wvalid(mem_wr.wvalid),
        .wready(mem_wr.wready), .bvalid(mem_wr.bvalid), .bready(mem_wr.bready),
        .done(mem_done)
    );

    axil_single_write u_tx_wr (
        .clk(clk), .rst_n(rst_n), .start(tx_start), .addr(UART_TX_DATA),
        .data(ack ? BOOT_ACK_WORD : BOOT_NAK_WORD),
        .awaddr(uart_wr.awaddr), .awvalid(uart_wr.awvalid), .awready(uart_wr.awready),
        .wdata(uart_wr.wdata), .wstrb(uart_wr.wstrb), .wvalid(uart_wr.wvalid),
        .wready(uart_wr.wready), .bvalid(uart_wr.bvalid), .bready(uart_wr.bready),
        .done(tx_done)
    );

    // NOTE: one clocked block with <= only; where two statements touch the same register the later one wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_POLL_HDR;
            data_phase      <= 1'b0;
            rd_valid        <= 1'b0;
            rd_ready        <= 1'b0;
            rd_addr         <= '0;
            image_len       <= '0;
            word            <= '0;
            addr            <= BASE_ADDR;
            words_remaining <= '0;
            wait_cnt        <= '0;
            wr_issued       <= 1'b0;
            ack             <= 1'b0;
            core_rst_n      <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            words_loaded    <= '0;
        end else begin
            if (mem_start || tx_start) wr_issued <= 1'b1;
            if (rd_valid && uart_rd.arready) begin
                rd_valid <= 1'b0;
                rd_ready <= 1'b1;
            end
            if (rd_fire) rd_ready <= 1'b0;

            unique case (state)
                ST_IDLE_WAIT: begin
                    if (wait_cnt == '0) state <= data_phase ? ST_POLL_DATA : ST_POLL_HDR;
                    else wait_cnt <= wait_cnt - 1'b1;
                end
                ST_POLL_HDR, ST_POLL_DATA: begin
                    if (rd_idle) begin
                        rd_valid <= 1'b1;
                        rd_addr  <= UART_RX_COUNT;
                    end
                    if (rd_fire) begin
                        if (uart_rd.rdata >= 64'd8) begin
                            state <= (state == ST_POLL_HDR) ? ST_POP_HDR : ST_POP_DATA;
                        end else begin
                            state    <= ST_IDLE_WAIT;
                            wait_cnt <= PCW'(POLL_INTERVAL - 1);
                        end
                    end
                end
                ST_POP_HDR, ST_POP_DATA: begin
                    if (rd_idle) begin
                        rd_valid <= 1'b1;
                        rd_addr  <= UART_RX_POP;
                    end
                    if (rd_fire) begin
                        if (state == ST_POP_HDR) begin
                            image_len <= uart_rd.rdata;
                            state     <= ST_CHECK;
                        end else begin
                            word  <= uart_rd.rdata;
                            state <= ST_MEM_WR;
                        end
                    end
                end
                ST_CHECK: begin
                    if (image_len != '0 && image_len[2:0] == 3'b000 &&
                        image_len <= 64'(MAX_IMAGE_BYTES)) begin
                        words_remaining <= image_len[WCW+2:3];
                        addr            <= BASE_ADDR;
                        data_phase      <= 1'b1;
                        state           <= ST_POLL_DATA;
                    end else begin
                        ack   <= 1'b0;
                        state <= ST_SEND_STATUS;
                    end
                end
                ST_MEM_WR: begin
                    if (mem_done) begin
                        wr_issued       <= 1'b0;
                        addr            <= addr + 64'd8;
                        words_loaded    <= words_loaded + WCW'(1);
                        words_remaining <= words_remaining - WCW'(1);
                        if (words_remaining == WCW'(1)) begin
                            ack   <= 1'b1;
                            state <= ST_SEND_STATUS;
                        end else begin
                            state <= ST_POLL_DATA;
                        end
                    end
                end
                ST_SEND_STATUS: begin
                    if (tx_done) begin
                        wr_issued <= 1'b0;
                        if (ack) begin
                            state      <= ST_DONE;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERROR: ;
                default: state <= ST_POLL_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench: UART and memory slave models push observed writes against
// queues of expected transactions filled by the directed scenarios.
module tb_uart_boot_loader;

    localparam logic [63:0] BASE     = 64'h1000;
    localparam int          MAXB     = 4096;
    localparam int          POLL_INT = 64;
    localparam logic [63:0] ACK_W    = 64'h0A4B4F5F544F4F42;
    localparam logic [63:0] NAK_W    = 64'h0A52455F544F4F42;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } mem_txn_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       core_rst_n, dut_done, dut_error;
    logic [9:0] words_loaded;

    axil_interface_if uart_rd_if ();
    axil_interface_if uart_wr_if ();
    axil_interface_if mem_wr_if ();

    uart_boot_loader #(.BASE_ADDR(BASE), .MAX_IMAGE_BYTES(MAXB), .POLL_INTERVAL(POLL_INT)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rd(uart_rd_if), .uart_wr(uart_wr_if),
        .mem_wr(mem_wr_if), .core_rst_n(core_rst_n), .done(dut_done),
        .error(dut_error), .words_loaded(words_loaded)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc_now = 0;
    initial forever begin
        @(posedge clk);
        cyc_now++;
    end

    logic [63:0] rx_q[$];
    mem_txn_t    exp_mem_q[$];
    logic [63:0] exp_tx_q[$];
    int          starve, poll_cnt, pop_cnt, mem_seen, last_poll_cyc;
    int          aw_dly, w_dly, b_dly;
    bit          prev_zero;
    logic [63:0] last_mem_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string got, input string req);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %s, required %s", name, got, req);
    endtask

    // Unused halves of the bundles are tied off so nothing floats.
    initial begin
        uart_rd_if.awready = 0; uart_rd_if.wready = 0; uart_rd_if.bvalid = 0; uart_rd_if.bresp = 0;
        uart_wr_if.arready = 0; uart_wr_if.rvalid = 0; uart_wr_if.rdata = 0; uart_wr_if.rresp = 0;
        mem_wr_if.arready = 0; mem_wr_if.rvalid = 0; mem_wr_if.rdata = 0; mem_wr_if.rresp = 0;
    end

    // UART read slave: RX count at 0, FIFO pop at 8.
    initial begin : rx_slave
        logic [63:0] a, val;
        int n, gap;
        uart_rd_if.arready = 0; uart_rd_if.rvalid = 0; uart_rd_if.rdata = 0; uart_rd_if.rresp = 0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && uart_rd_if.arvalid) begin
                a = uart_rd_if.araddr;
                uart_rd_if.arready = 1;
                @(posedge clk); #1;
                uart_rd_if.arready = 0;
                if (rst_n) begin
                    val = 64'd0;
                    if (a == 64'd0) begin
                        poll_cnt++;
                        if (prev_zero) begin
                            gap = cyc_now - last_poll_cyc;
                            n_checks++;
                            if (gap < POLL_INT) begin
                                n_fail++;
                                $display("FAIL poll_spacing: got %0d cycles, required >= %0d", gap, POLL_INT);
                            end
                        end
                        last_poll_cyc = cyc_now;
                        if (starve > 0) starve--;
                        else val = 64'(rx_q.size()) << 3;
                        prev_zero = (val == 64'd0);
                    end else if (a == 64'd8) begin
                        pop_cnt++;
                        if (rx_q.size() == 0) fail("pop_empty", "pop of empty FIFO", "count >= 8 first");
                        else val = rx_q.pop_front();
                    end else begin
                        fail("rd_addr", $sformatf("%h", a), "0 or 8");
                    end
                    uart_rd_if.rdata  = val;
                    uart_rd_if.rvalid = 1;
                    n = 0;
                    while (rst_n && !uart_rd_if.rready && n < 50) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    if (rst_n && uart_rd_if.rready) begin
                        @(posedge clk); #1;
                    end else if (rst_n) begin
                        fail("rready_timeout", "rready low", "rready high");
                    end
                    uart_rd_if.rvalid = 0;
                end
            end
        end
    end

    // Memory write slave with programmable AW / W / B delays; compares on B.
    initial begin : mem_slave
        logic [63:0] a0, d0;
        bit aw_ok, w_ok, abort;
        int cyc, n;
        mem_txn_t e;
        mem_wr_if.awready = 0; mem_wr_if.wready = 0; mem_wr_if.bvalid = 0; mem_wr_if.bresp = 0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && mem_wr_if.awvalid) begin
                a0 = mem_wr_if.awaddr;
                d0 = mem_wr_if.wdata;
                check("mem_wvalid_with_awvalid", mem_wr_if.wvalid, 1);
                aw_ok = 0; w_ok = 0; abort = 0; cyc = 0;
                while (!(aw_ok && w_ok) && !abort) begin
                    if (!aw_ok) begin
                        check("mem_aw_hold_valid", mem_wr_if.awvalid, 1);
                        check("mem_aw_hold_addr", mem_wr_if.awaddr, a0);
                    end
                    if (!w_ok) begin
                        check("mem_w_hold_valid", mem_wr_if.wvalid, 1);
                        check("mem_w_hold_data", mem_wr_if.wdata, d0);
                    end
                    mem_wr_if.awready = !aw_ok && (cyc >= aw_dly);
                    mem_wr_if.wready  = !w_ok && (cyc >= w_dly);
                    @(posedge clk); #1;
                    if (!rst_n) begin
                        abort = 1;
                    end else begin
                        if (mem_wr_if.awready) begin
                            aw_ok = 1;
                            check("mem_aw_drop", mem_wr_if.awvalid, 0);
                        end
                        if (mem_wr_if.wready) begin
                            w_ok = 1;
                            check("mem_w_drop", mem_wr_if.wvalid, 0);
                        end
                    end
                    mem_wr_if.awready = 0;
                    mem_wr_if.wready  = 0;
                    cyc++;
                    if (cyc > 200) begin
                        fail("mem_aw_w_timeout", "no handshake", "handshake within 200 cycles");
                        abort = 1;
                    end
                end
                if (!abort) begin
                    repeat (b_dly) begin
                        @(posedge clk); #1;
                    end
                    mem_wr_if.bvalid = 1;
                    n = 0;
                    while (rst_n && !mem_wr_if.bready && n < 50) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    if (rst_n && mem_wr_if.bready) begin
                        @(posedge clk); #1;
                        mem_seen++;
                        last_mem_addr = a0;
                        if (exp_mem_q.size() == 0) begin
                            fail("mem_unexpected_write", $sformatf("write to %h", a0), "no write");
                        end else begin
                            e = exp_mem_q.pop_front();
                            check("mem_addr", a0, e.addr);
                            check("mem_data", d0, e.data);
                        end
                    end else if (rst_n) begin
                        fail("mem_bready_timeout", "bready low", "bready high");
                    end
                    mem_wr_if.bvalid = 0;
                end
            end
        end
    end

    // UART TX write slave: always ready, compares the status word on B.
    initial begin : tx_slave
        logic [63:0] tx_data;
        int n;
        uart_wr_if.awready = 0; uart_wr_if.wready = 0; uart_wr_if.bvalid = 0; uart_wr_if.bresp = 0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && uart_wr_if.awvalid) begin
                check("tx_wvalid_with_awvalid", uart_wr_if.wvalid, 1);
                check("tx_addr", uart_wr_if.awaddr, 64'd24);
                tx_data = uart_wr_if.wdata;
                uart_wr_if.awready = 1;
                uart_wr_if.wready  = 1;
                @(posedge clk); #1;
                uart_wr_if.awready = 0;
                uart_wr_if.wready  = 0;
                if (rst_n) begin
                    uart_wr_if.bvalid = 1;
                    n = 0;
                    while (rst_n && !uart_wr_if.bready && n < 50) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    if (rst_n && uart_wr_if.bready) begin
                        @(posedge clk); #1;
                        if (exp_tx_q.size() == 0)
                            fail("tx_unexpected_write", $sformatf("%h", tx_data), "no TX write");
                        else
                            check("tx_data", tx_data, exp_tx_q.pop_front());
                    end else if (rst_n) begin
                        fail("tx_bready_timeout", "bready low", "bready high");
                    end
                    uart_wr_if.bvalid = 0;
                end
            end
        end
    end

    task automatic reset_on();
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rx_q.delete();
        exp_mem_q.delete();
        exp_tx_q.delete();
        starve = 0; poll_cnt = 0; pop_cnt = 0; mem_seen = 0; prev_zero = 0;
        aw_dly = 0; w_dly = 0; b_dly = 0;
        last_mem_addr = '0;
    endtask

    task automatic reset_off();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic push_mem(input logic [63:0] a, input logic [63:0] d);
        mem_txn_t t;
        t.addr = a;
        t.data = d;
        exp_mem_q.push_back(t);
    endtask

    task automatic wait_end(input string name, input int budget);
        int n = 0;
        while (!(dut_done || dut_error) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_finished"}, dut_done | dut_error, 1);
        repeat (2) @(negedge clk);
        check({name, "_mem_left"}, exp_mem_q.size(), 0);
        check({name, "_tx_left"}, exp_tx_q.size(), 0);
    endtask

    task automatic bad_header(input string name, input logic [63:0] len);
        reset_on();
        rx_q.push_back(len);
        exp_tx_q.push_back(NAK_W);
        reset_off();
        wait_end(name, 2000);
        check({name, "_error"}, dut_error, 1);
        check({name, "_done"}, dut_done, 0);
        check({name, "_core_rst_n"}, core_rst_n, 0);
        check({name, "_mem_writes"}, mem_seen, 0);
        check({name, "_words_loaded"}, words_loaded, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL global_timeout: got no end of test, required end within 2 ms");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int n;
        // Reset state
        reset_on();
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_done", dut_done, 0);
        check("rst_error", dut_error, 0);
        check("rst_words_loaded", words_loaded, 0);
        check("rst_arvalid", uart_rd_if.arvalid, 0);
        check("rst_rready", uart_rd_if.rready, 0);
        check("rst_mem_awvalid", mem_wr_if.awvalid, 0);
        check("rst_mem_wvalid", mem_wr_if.wvalid, 0);
        check("rst_mem_bready", mem_wr_if.bready, 0);
        check("rst_tx_awvalid", uart_wr_if.awvalid, 0);

        // Nominal two-word load
        rx_q = '{64'd16, 64'h1111111111111111, 64'h2222222222222222};
        push_mem(64'h1000, 64'h1111111111111111);
        push_mem(64'h1008, 64'h2222222222222222);
        exp_tx_q.push_back(ACK_W);
        reset_off();
        @(posedge clk); #1;
        check("first_poll_arvalid", uart_rd_if.arvalid, 1);
        check("first_poll_araddr", uart_rd_if.araddr, 64'd0);
        wait_end("nominal", 2000);
        check("nominal_words_loaded", words_loaded, 2);
        check("nominal_done", dut_done, 1);
        check("nominal_core_rst_n", core_rst_n, 1);
        check("nominal_error", dut_error, 0);

        // Rejected headers: not word-aligned, one word too large, zero
        bad_header("bad_len12", 64'd12);
        bad_header("bad_len_over", 64'd4104);
        bad_header("bad_len0", 64'd0);

        // Starved RX: five empty polls before the header is available
        reset_on();
        starve = 5;
        rx_q = '{64'd8, 64'hDEADBEEF0BADF00D};
        push_mem(64'h1000, 64'hDEADBEEF0BADF00D);
        exp_tx_q.push_back(ACK_W);
        reset_off();
        wait_end("starved", 3000);
        check("starved_polls", poll_cnt, 7);
        check("starved_pops", pop_cnt, 2);
        check("starved_words_loaded", words_loaded, 1);
        check("starved_done", dut_done, 1);

        // Memory backpressure
        reset_on();
        aw_dly = 3; w_dly = 7; b_dly = 2;
        rx_q = '{64'd16, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
        push_mem(64'h1000, 64'h0123456789ABCDEF);
        push_mem(64'h1008, 64'hFEDCBA9876543210);
        exp_tx_q.push_back(ACK_W);
        reset_off();
        wait_end("backpressure", 3000);
        check("bp_words_loaded", words_loaded, 2);
        check("bp_mem_writes", mem_seen, 2);
        check("bp_done", dut_done, 1);

        // Reset while a memory write address is outstanding
        reset_on();
        aw_dly = 20;
        rx_q = '{64'd16, 64'h5555555555555555, 64'h6666666666666666};
        reset_off();
        n = 0;
        while (!mem_wr_if.awvalid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rmw_awvalid_seen", mem_wr_if.awvalid, 1);
        rst_n = 0;
        @(posedge clk); #1;
        check("rmw_awvalid", mem_wr_if.awvalid, 0);
        check("rmw_wvalid", mem_wr_if.wvalid, 0);
        check("rmw_bready", mem_wr_if.bready, 0);
        check("rmw_arvalid", uart_rd_if.arvalid, 0);
        check("rmw_rready", uart_rd_if.rready, 0);
        check("rmw_tx_awvalid", uart_wr_if.awvalid, 0);
        check("rmw_core_rst_n", core_rst_n, 0);
        check("rmw_done", dut_done, 0);
        check("rmw_words_loaded", words_loaded, 0);
        rx_q.delete();
        aw_dly = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        check("rmw_restart_arvalid", uart_rd_if.arvalid, 1);
        check("rmw_restart_araddr", uart_rd_if.araddr, 64'd0);
        check("rmw_mem_writes", mem_seen, 0);

        // Largest accepted image
        reset_on();
        rx_q.push_back(64'(MAXB));
        for (int i = 0; i < MAXB / 8; i++) begin
            rx_q.push_back(64'hA5A5_0000_0000_0000 | 64'(i * 3));
            push_mem(BASE + 64'(i * 8), 64'hA5A5_0000_0000_0000 | 64'(i * 3));
        end
        exp_tx_q.push_back(ACK_W);
        reset_off();
        wait_end("max_image", 20000);
        check("max_words_loaded", words_loaded, 512);
        check("max_last_addr", last_mem_addr, 64'h1FF8);
        check("max_done", dut_done, 1);
        check("max_core_rst_n", core_rst_n, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Boot-time image loader sitting directly downstream of the memory-mapped UART peripheral. It acts as an AXI4-Lite master on the UART's read and write ports, receives a length-prefixed program image from the host, and writes it word-by-word into instruction/data memory through a third AXI4-Lite master port. It holds the CPU core in reset until the image is committed. When finished it returns an 8-byte status string to the host through the UART TX buffer.

## Interface
- `BASE_ADDR`, 64'h0: memory address of the first image word.
- `MAX_IMAGE_BYTES`, 4096: largest accepted image; must be a multiple of 8.
- `POLL_INTERVAL`, 64: idle cycles between successive UART RX-count polls (≥1).
- `clk` input 1: sole clock.
- `rst_n` input 1: synchronous, active-low reset.
- `uart_rd` `axil_interface_if.rd_mst`: master on UART read port. UART registers: 0 = RX byte count; 8 = pop 64 bits; 16 = TX byte count.
- `uart_wr` `axil_interface_if.wr_mst`: master on UART write port. Register 24 = push 64 bits to TX.
- `mem_wr` `axil_interface_if.wr_mst`: master on memory write port, 64-bit data.
- `core_rst_n` output 1: low while loading; high only in DONE.
- `done` output 1: image loaded and ACK queued.
- `error` output 1: header rejected and NAK queued.
- `words_loaded` output `$clog2(MAX_IMAGE_BYTES/8)+1`: count of memory writes that received `bvalid`.

## Operation
- **States:** IDLE_WAIT → POLL_HDR → POP_HDR → CHECK → POLL_DATA → POP_DATA → MEM_WR → (POLL_DATA | SEND_STATUS) → DONE / ERROR.
- **IDLE_WAIT:** count down `POLL_INTERVAL`, then go to POLL_HDR or POLL_DATA (remembered phase).
- **POLL_\*:** read addr 0.
  - If `rdata` ≥ 8, go to the POP state.
  - Otherwise return to IDLE_WAIT.
- **POP_HDR:** read addr 8. `rdata` = image length L in bytes, little-endian, latched.
- **CHECK:** L accepted iff L ≠ 0, L[2:0] == 0, and L ≤ `MAX_IMAGE_BYTES`.
  - Accepted: words_remaining = L>>3, addr = `BASE_ADDR` → POLL_DATA.
  - Rejected: status = NAK → SEND_STATUS.
- **POP_DATA:** read addr 8, latch `rdata` as the data word → MEM_WR.
- **MEM_WR:** `awaddr`=addr, `wdata`=word, `wstrb` all ones.
  - On `bvalid`: addr += 8, `words_loaded` += 1, words_remaining −= 1.
  - If words_remaining is now 0: status = ACK → SEND_STATUS; else → POLL_DATA.
- **SEND_STATUS:** write the status word to UART addr 24.
  - ACK = 64'h0A4B4F5F544F4F42 ("BOOT_OK\n" LSB-first).
  - NAK = 64'h0A52455F544F4F42 ("BOOT_ER\n").
  - On `bvalid` → DONE (ACK) or ERROR (NAK).
- **DONE / ERROR:** terminal until reset. DONE drives `done`=1 and `core_rst_n`=1. ERROR drives `error`=1; `core_rst_n` stays 0.
- `bresp`/`rresp` are ignored.
- **Address arithmetic:** 64-bit wrap, no overflow check. Words are never split; the loader pops only when count ≥ 8.

## Timing
- **Reset values:**
  - All `*valid` = 0; `rready` = 0; `bready` = 0.
  - `core_rst_n`=0, `done`=0, `error`=0, `words_loaded`=0.
  - State = POLL_HDR; the first poll is issued on the cycle after reset deasserts.
- **Reads:** one outstanding at a time.
  - `arvalid` asserted with a stable `araddr` and held until `arready`.
  - `rready` = 1 in every state awaiting read data; data is captured on `rvalid`.
  - The next AR is issued no earlier than the cycle after `rvalid`&&`rready`.
- **Writes:** `awvalid` and `wvalid` rise together.
  - Each is dropped independently after its own handshake (`awready`/`wready` may arrive in different cycles).
  - `bready` = 1 once both handshakes are complete; the state advances on `bvalid`.
- **Minimum cycles per image word:** poll (≥2) + pop (≥2) + mem write (≥2).
- **Reset mid-transaction:** all valids drop in the reset cycle, and the in-flight transaction is abandoned. UART-side bytes already popped are lost; the host must retransmit.
- `words_loaded` updates in the cycle after the `bvalid` handshake.
- `done` and `core_rst_n` rise in the same cycle.

## Structure
- **Package `uart_boot_pkg`:**
  - UART register offsets: `UART_RX_COUNT`=0, `UART_RX_POP`=8, `UART_TX_COUNT`=16, `UART_TX_DATA`=24.
  - `BOOT_ACK_WORD`, `BOOT_NAK_WORD`.
  - Loader state enum.
- **Sub-module `axil_single_write`:** one-shot write master (start pulse → AW/W/B sequencing → done pulse). Instantiated twice, for `mem_wr` and `uart_wr`.
- **Read sequencing:** stays inline in the top-level FSM.

## Test plan
- **Nominal load:**
  - Stimulus: host BFM supplies header 16 and words 64'h1111…, 64'h2222…; `BASE_ADDR`=64'h1000.
  - Required: mem writes to 0x1000 and 0x1008 with those values; `words_loaded`=2; UART addr 24 receives 64'h0A4B4F5F544F4F42; `done`=1 and `core_rst_n`=1.
- **Bad header:**
  - Stimulus: header 12, then separately header `MAX_IMAGE_BYTES`+8.
  - Required: no mem writes; NAK word written; `error`=1; `core_rst_n`=0.
- **Starved RX:**
  - Stimulus: UART count returns 0 five times, then 8.
  - Required: polls spaced ≥`POLL_INTERVAL` cycles apart; exactly one pop after the count reaches 8.
- **Backpressure:**
  - Stimulus: mem `awready` delayed 3 cycles, `wready` delayed 7, `bvalid` delayed 2.
  - Required: `awvalid`/`wvalid` held stable until their own handshakes; a single write per word.
- **Reset mid-write:**
  - Stimulus: `rst_n`=0 while `awvalid`=1.
  - Required: all outputs at reset values in the following cycle; restart issues a read to addr 0.
- **Max image:**
  - Stimulus: `MAX_IMAGE_BYTES` image.
  - Required: `words_loaded`=512; last address `BASE_ADDR`+4088; ACK sent.
